// File: rtl/sm4_cbc_ctrl_if.sv
// Handshake and data bus between the CBC chaining controller, its message
// source/sink and the SM4 block core.
interface sm4_cbc_ctrl_if;
  logic         mode_sel_in;
  logic         iv_valid_in;
  logic [127:0] iv_in;
  logic         blk_valid_in;
  logic [127:0] blk_data_in;
  logic         blk_last_in;
  logic         blk_ready_out;
  logic         core_valid_out;
  logic [127:0] core_data_out;
  logic         core_ready_in;
  logic [127:0] core_result_in;
  logic         res_valid_out;
  logic [127:0] res_data_out;
  logic         res_last_out;
  logic         res_ready_in;
  logic         error_out;

  modport master (
    output mode_sel_in, iv_valid_in, iv_in,
    output blk_valid_in, blk_data_in, blk_last_in,
    output core_ready_in, core_result_in, res_ready_in,
    input  blk_ready_out, core_valid_out, core_data_out,
    input  res_valid_out, res_data_out, res_last_out, error_out
  );

  modport slave (
    input  mode_sel_in, iv_valid_in, iv_in,
    input  blk_valid_in, blk_data_in, blk_last_in,
    input  core_ready_in, core_result_in, res_ready_in,
    output blk_ready_out, core_valid_out, core_data_out,
    output res_valid_out, res_data_out, res_last_out, error_out
  );
endinterface

// File: rtl/sm4_cbc_ctrl.sv
// CBC chaining controller around an SM4 block core: one block in flight,
// encrypt or decrypt chosen per message at IV load, with a core watchdog.
module sm4_cbc_ctrl (
  input logic           clk,
  input logic           reset,
  sm4_cbc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READY, ISSUE, WAIT, OUT} state_t;

  // Last WAIT count value: the 255th WAIT cycle without a core response.
  localparam logic [7:0] WD_LAST = 8'd254;

  state_t       state_q, state_d;
  logic [127:0] chain_q;
  logic [127:0] cin_q;
  logic [127:0] res_q;
  logic [127:0] core_data_q;
  logic [7:0]   wd_cnt_q;
  logic         mode_q;
  logic         last_q;
  logic         error_q;
  logic         wd_expired;

  assign wd_expired = (wd_cnt_q == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.iv_valid_in)  state_d = READY;
      READY: if (bus.blk_valid_in) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.core_ready_in)   state_d = OUT;
        else if (wd_expired)     state_d = IDLE;
      end
      OUT:   if (bus.res_ready_in) state_d = last_q ? IDLE : READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q     <= '0;
      cin_q       <= '0;
      res_q       <= '0;
      core_data_q <= '0;
      wd_cnt_q    <= '0;
      mode_q      <= 1'b0;
      last_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.iv_valid_in) begin
            chain_q <= bus.iv_in;
            mode_q  <= bus.mode_sel_in;
            error_q <= 1'b0;
          end
        end
        READY: begin
          if (bus.blk_valid_in) begin
            cin_q       <= bus.blk_data_in;
            last_q      <= bus.blk_last_in;
            core_data_q <= mode_q ? bus.blk_data_in : (bus.blk_data_in ^ chain_q);
          end
        end
        ISSUE: wd_cnt_q <= '0;
        WAIT: begin
          // Decrypt chains on the ciphertext just consumed, encrypt on the core output.
          if (bus.core_ready_in) begin
            if (mode_q) begin
              res_q   <= bus.core_result_in ^ chain_q;
              chain_q <= cin_q;
            end else begin
              res_q   <= bus.core_result_in;
              chain_q <= bus.core_result_in;
            end
          end else if (wd_expired) begin
            error_q <= 1'b1;
            chain_q <= '0;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.blk_ready_out  = (state_q == READY);
  assign bus.core_valid_out = (state_q == ISSUE);
  assign bus.core_data_out  = core_data_q;
  assign bus.res_valid_out  = (state_q == OUT);
  assign bus.res_data_out   = res_q;
  assign bus.res_last_out   = (state_q == OUT) && last_q;
  assign bus.error_out      = error_q;

endmodule

// File: tb/tb_sm4_cbc_ctrl.sv
// Bench for sm4_cbc_ctrl: CBC reference model plus an SM4 core stand-in that
// knows the published test-key vectors and uses a fixed XOR mask otherwise.
module tb_sm4_cbc_ctrl;

  localparam logic [127:0] P0     = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C0     = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] P2     = 128'h693d9a535bad5bb1786f53d7253a7056;
  localparam logic [127:0] K_FAKE = 128'h5a5ac3c3_0f0ff0f0_a5a53c3c_96966969;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sm4_cbc_ctrl_if bus();

  sm4_cbc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [127:0] exp_core_q[$];
  res_t         exp_res_q[$];
  logic [127:0] core_log[$];
  res_t         res_log[$];

  logic         m_mode;
  logic [127:0] m_chain;
  logic         core_enable = 1'b1;
  int           core_lat    = 3;
  logic         core_mode   = 1'b0;

  function automatic logic [127:0] core_fn(input logic dec, input logic [127:0] x);
    if (!dec && x == P0) return C0;
    if (dec && x == C0)  return P0;
    return x ^ K_FAKE;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare process: every issued core block and every accepted result.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.core_valid_out) begin
          core_log.push_back(bus.core_data_out);
          if (exp_core_q.size() == 0) fail_now("core_unexpected", $sformatf("got %h expected none", bus.core_data_out));
          else check("core_data", bus.core_data_out, exp_core_q.pop_front());
        end
        if (bus.res_valid_out && bus.res_ready_in) begin
          res_log.push_back('{data: bus.res_data_out, last: bus.res_last_out});
          if (exp_res_q.size() == 0) fail_now("res_unexpected", $sformatf("got %h expected none", bus.res_data_out));
          else begin
            r = exp_res_q.pop_front();
            check("res_data", bus.res_data_out, r.data);
            check("res_last", 128'(bus.res_last_out), 128'(r.last));
          end
        end
      end
    end
  end

  // SM4 core stand-in: answers each start pulse core_lat cycles later.
  initial begin
    logic [127:0] d;
    logic         m;
    bus.core_ready_in  = 1'b0;
    bus.core_result_in = '0;
    forever begin
      @(negedge clk);
      if (bus.core_valid_out && !reset && core_enable) begin
        d = bus.core_data_out;
        m = core_mode;
        repeat (core_lat) @(posedge clk);
        #1;
        bus.core_result_in = core_fn(m, d);
        bus.core_ready_in  = 1'b1;
        @(posedge clk);
        #1;
        bus.core_ready_in  = 1'b0;
      end
    end
  end

  task automatic load_iv(input logic dec, input logic [127:0] iv);
    bus.mode_sel_in = dec;
    bus.iv_in       = iv;
    bus.iv_valid_in = 1'b1;
    step();
    bus.iv_valid_in = 1'b0;
    m_mode    = dec;
    m_chain   = iv;
    core_mode = dec;
    core_log.delete();
    res_log.delete();
  endtask

  task automatic send_blk(input logic [127:0] d, input logic last, input logic expect_res);
    int t = 0;
    logic [127:0] cd, r, o;
    while (!bus.blk_ready_out && t < 1000) begin
      step();
      t++;
    end
    if (!bus.blk_ready_out) begin
      fail_now("blk_ready_timeout", "blk_ready_out never rose, required 1");
      return;
    end
    cd = m_mode ? d : (d ^ m_chain);
    exp_core_q.push_back(cd);
    if (expect_res) begin
      r = core_fn(m_mode, cd);
      o = m_mode ? (r ^ m_chain) : r;
      m_chain = m_mode ? d : r;
      exp_res_q.push_back('{data: o, last: last});
    end
    bus.blk_data_in  = d;
    bus.blk_last_in  = last;
    bus.blk_valid_in = 1'b1;
    step();
    bus.blk_valid_in = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_res_q.size() != 0 && t < 2000) begin
      step();
      t++;
    end
    if (exp_res_q.size() != 0) fail_now("drain_timeout", $sformatf("%0d results pending, required 0", exp_res_q.size()));
    step(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_blk_ready"},  128'(bus.blk_ready_out),  '0);
    check({tag, "_core_valid"}, 128'(bus.core_valid_out), '0);
    check({tag, "_core_data"},  bus.core_data_out,        '0);
    check({tag, "_res_valid"},  128'(bus.res_valid_out),  '0);
    check({tag, "_res_data"},   bus.res_data_out,         '0);
    check({tag, "_res_last"},   128'(bus.res_last_out),   '0);
    check({tag, "_error"},      128'(bus.error_out),      '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int any_res;
    reset            = 1'b1;
    bus.mode_sel_in  = 1'b0;
    bus.iv_valid_in  = 1'b0;
    bus.iv_in        = '0;
    bus.blk_valid_in = 1'b0;
    bus.blk_data_in  = '0;
    bus.blk_last_in  = 1'b0;
    bus.res_ready_in = 1'b1;
    step(3);
    check_all_zero("reset");
    reset = 1'b0;
    step(2);

    // Encrypt, single block
    load_iv(1'b0, '0);
    send_blk(P0, 1'b1, 1'b1);
    drain();
    check("t1_core_count", 128'(core_log.size()), 128'd1);
    check("t1_core_data",  core_log[0], P0);
    check("t1_res_data",   res_log[0].data, C0);
    check("t1_res_last",   128'(res_log[0].last), 128'd1);
    step(3);
    check("t1_idle_no_ready", 128'(bus.blk_ready_out), '0);

    // Encrypt, two blocks; an IV strobe mid-message must be ignored
    load_iv(1'b0, '0);
    send_blk(P0, 1'b0, 1'b1);
    bus.iv_in = K_FAKE; bus.mode_sel_in = 1'b1; bus.iv_valid_in = 1'b1;
    step();
    bus.iv_valid_in = 1'b0; bus.mode_sel_in = 1'b0;
    send_blk(P2, 1'b1, 1'b1);
    drain();
    check("t2_core1", core_log[1], P0);
    check("t2_res0",  res_log[0].data, C0);
    check("t2_res1",  res_log[1].data, C0);

    // Decrypt, same ciphertext twice
    load_iv(1'b1, '0);
    send_blk(C0, 1'b0, 1'b1);
    send_blk(C0, 1'b1, 1'b1);
    drain();
    check("t3_res0", res_log[0].data, P0);
    check("t3_res1", res_log[1].data, P2);
    check("t3_last", 128'(res_log[1].last), 128'd1);

    // Arbitrary data, nonzero IVs, varied core latency
    core_lat = 1;
    load_iv(1'b0, 128'hfedcba98_76543210_01234567_89abcdef);
    send_blk(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1);
    send_blk(128'hdeadbeef_cafef00d_12345678_9abcdef0, 1'b0, 1'b1);
    send_blk(128'h0, 1'b1, 1'b1);
    drain();
    core_lat = 6;
    load_iv(1'b1, 128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978);
    send_blk(128'h11111111_22222222_33333333_44444444, 1'b0, 1'b1);
    send_blk(128'hffffffff_00000000_ffffffff_00000000, 1'b1, 1'b1);
    drain();
    core_lat = 3;

    // Result back-pressure for 10 cycles
    load_iv(1'b0, '0);
    bus.res_ready_in = 1'b0;
    send_blk(P0, 1'b1, 1'b1);
    t = 0;
    while (!bus.res_valid_out && t < 200) begin step(); t++; end
    if (!bus.res_valid_out) fail_now("t5_res_valid_timeout", "res_valid_out never rose, required 1");
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_data",  bus.res_data_out, C0);
      check("t5_hold_valid", 128'(bus.res_valid_out), 128'd1);
      check("t5_hold_last",  128'(bus.res_last_out), 128'd1);
      check("t5_no_ready",   128'(bus.blk_ready_out), '0);
      step();
    end
    check("t5_single_issue", 128'(core_log.size()), 128'd1);
    bus.res_ready_in = 1'b1;
    drain();

    // Core never answers: watchdog fires on the 255th WAIT cycle
    core_enable = 1'b0;
    load_iv(1'b0, '0);
    send_blk(P0, 1'b1, 1'b0);
    check("t6_issue", 128'(bus.core_valid_out), 128'd1);
    step(255);
    check("t6_error_before", 128'(bus.error_out), '0);
    step();
    check("t6_error_set", 128'(bus.error_out), 128'd1);
    check("t6_idle_no_ready", 128'(bus.blk_ready_out), '0);
    step(3);
    check("t6_error_sticky", 128'(bus.error_out), 128'd1);
    core_enable = 1'b1;
    load_iv(1'b0, '0);
    check("t6_error_cleared", 128'(bus.error_out), '0);
    send_blk(P0, 1'b1, 1'b1);
    drain();
    check("t6_recover_res", res_log[0].data, C0);

    // Reset while waiting on the core; the late answer must be dropped
    core_lat = 6;
    load_iv(1'b0, '0);
    send_blk(P0, 1'b1, 1'b1);
    step(2);
    reset = 1'b1;
    #1;
    check_all_zero("t7_reset");
    step();
    reset = 1'b0;
    exp_res_q.delete();
    exp_core_q.delete();
    any_res = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.res_valid_out) any_res++;
      step();
    end
    check("t7_no_res_after_reset", 128'(any_res), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
